mul_acc_unit: RTL and testbench

MUL_ACC_UNIT -- requirements
Module: mul_acc_unit

---
 rtl/mul_acc_unit_pkg.sv | 39 +++
 rtl/mul_acc_unit_mul_pipe.sv | 69 ++++++
 rtl/mul_acc_unit.sv | 135 +++++++++++++
 tb/tb_mul_acc_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_unit_pkg.sv
// Shared definitions for the multiply/accumulate unit: operation codes,
// HI/LO word positions and small opcode classification helpers.
package mul_acc_unit_pkg;

    typedef enum logic [3:0] {
        MOP_MULT  = 4'd0,
        MOP_MULTU = 4'd1,
        MOP_MUL   = 4'd2,
        MOP_MADD  = 4'd3,
        MOP_MADDU = 4'd4,
        MOP_MSUB  = 4'd5,
        MOP_MSUBU = 4'd6,
        MOP_MTHI  = 4'd7,
        MOP_MTLO  = 4'd8,
        MOP_MFHI  = 4'd9,
        MOP_MFLO  = 4'd10
    } mop_e;

    // Word indices into the {HI,LO} register; slice as [IDX*DATA_W +: DATA_W].
    localparam int HI_WORD = 1;
    localparam int LO_WORD = 0;

    function automatic logic is_defined_op(input logic [3:0] op);
        return op <= MOP_MFLO;
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return op inside {MOP_MULT, MOP_MULTU, MOP_MUL, MOP_MADD, MOP_MADDU, MOP_MSUB, MOP_MSUBU};
    endfunction

    function automatic logic is_acc_op(input logic [3:0] op);
        return op inside {MOP_MADD, MOP_MADDU, MOP_MSUB, MOP_MSUBU};
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {MOP_MULT, MOP_MUL, MOP_MADD, MOP_MSUB};
    endfunction

endpackage

// File: rtl/mul_acc_unit_mul_pipe.sv
// Multiplier datapath: magnitude partial products summed on entry, then a
// MUL_STAGES-deep product/sign/valid pipeline with sign fix-up at the output.
module mul_pipe #(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kill_i,
    input  logic                  in_valid_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  out_valid_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int NUM_PP = DATA_W / 2;

    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_W-1:0]     mag_a;
    logic [DATA_W-1:0]     mag_b;
    logic [PROD_W-1:0]     mag_prod;

    logic [MUL_STAGES-1:0] valid_q;
    logic [MUL_STAGES-1:0] neg_q;
    logic [PROD_W-1:0]     prod_q [MUL_STAGES];

    // The most negative operand maps to 2^(DATA_W-1), which still fits unsigned.
    always_comb begin
        sign_a = signed_i & a_i[DATA_W-1];
        sign_b = signed_i & b_i[DATA_W-1];
        mag_a  = sign_a ? -a_i : a_i;
        mag_b  = sign_b ? -b_i : b_i;
        // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
        mag_prod = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            mag_prod = mag_prod + ((PROD_W'(mag_a) * PROD_W'(mag_b[2*i +: 2])) << (2 * i));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || kill_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid_i;
            for (int k = 1; k < MUL_STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    // NOTE: datapath registers carry no reset; only the valid bits qualify their contents.
    always_ff @(posedge clk) begin
        neg_q[0]  <= sign_a ^ sign_b;
        prod_q[0] <= mag_prod;
        for (int k = 1; k < MUL_STAGES; k++) begin
            neg_q[k]  <= neg_q[k-1];
            prod_q[k] <= prod_q[k-1];
        end
    end

    assign out_valid_o = valid_q[MUL_STAGES-1];
    assign product_o   = neg_q[MUL_STAGES-1] ? -prod_q[MUL_STAGES-1] : prod_q[MUL_STAGES-1];

endmodule

// File: rtl/mul_acc_unit.sv
// Multiply/accumulate unit: owns the architectural {HI,LO} register, op
// acceptance, flush/reset cancellation and result reporting around mul_pipe.
module mul_acc_unit
    import mul_acc_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2,
    parameter int ACC_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [3:0]            op,
    input  logic [DATA_W-1:0]     src_a,
    input  logic [DATA_W-1:0]     src_b,
    input  logic                  flush,
    output logic                  op_ready,
    output logic                  res_valid,
    output logic [DATA_W-1:0]     res,
    output logic                  err,
    output logic [2*DATA_W-1:0]   hilo
);

    localparam int HI_LSB = HI_WORD * DATA_W;
    localparam int LO_LSB = LO_WORD * DATA_W;

    logic                  busy_q, busy_d;
    mop_e                  op_q, op_d;
    logic [2*DATA_W-1:0]   hilo_q, hilo_d;
    logic [DATA_W-1:0]     res_q, res_d;
    logic                  res_valid_q, res_valid_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  op_legal;
    logic                  start_mul;
    logic                  mul_signed;
    logic                  complete;
    logic                  pipe_valid;
    logic [2*DATA_W-1:0]   pipe_prod;

    always_comb begin
        accept     = op_valid && !busy_q && !flush;
        op_legal   = is_defined_op(op) && (ACC_EN != 0 || !is_acc_op(op));
        start_mul  = accept && op_legal && is_mul_op(op);
        mul_signed = is_signed_op(op);
        // A flush in the completion cycle wins over the write-back.
        complete   = pipe_valid && busy_q && !flush;
    end

    mul_pipe #(
        .DATA_W     (DATA_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul_pipe (
        .clk         (clk),
        .rst         (rst),
        .kill_i      (flush),
        .in_valid_i  (start_mul),
        .signed_i    (mul_signed),
        .a_i         (src_a),
        .b_i         (src_b),
        .out_valid_o (pipe_valid),
        .product_o   (pipe_prod)
    );

    always_comb begin
        busy_d      = busy_q;
        op_d        = op_q;
        hilo_d      = hilo_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        err_d       = 1'b0;

        if (complete) begin
            busy_d      = 1'b0;
            res_valid_d = 1'b1;
            case (op_q)
                MOP_MULT, MOP_MULTU: hilo_d = pipe_prod;
                MOP_MADD, MOP_MADDU: hilo_d = hilo_q + pipe_prod;
                MOP_MSUB, MOP_MSUBU: hilo_d = hilo_q - pipe_prod;
                MOP_MUL:             res_d  = pipe_prod[DATA_W-1:0];
                default: ;
            endcase
        end else if (busy_q && flush) begin
            busy_d = 1'b0;
        end else if (accept) begin
            if (!op_legal) begin
                err_d = 1'b1;
            end else begin
                case (mop_e'(op))
                    MOP_MULT, MOP_MULTU, MOP_MUL, MOP_MADD, MOP_MADDU, MOP_MSUB, MOP_MSUBU: begin
                        busy_d = 1'b1;
                        op_d   = mop_e'(op);
                    end
                    MOP_MTHI: hilo_d[HI_LSB +: DATA_W] = src_a;
                    MOP_MTLO: hilo_d[LO_LSB +: DATA_W] = src_a;
                    MOP_MFHI: begin
                        res_d       = hilo_q[HI_LSB +: DATA_W];
                        res_valid_d = 1'b1;
                    end
                    MOP_MFLO: begin
                        res_d       = hilo_q[LO_LSB +: DATA_W];
                        res_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            op_q        <= MOP_MULT;
            hilo_q      <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            op_q        <= op_d;
            hilo_q      <= hilo_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign op_ready  = !busy_q;
    assign res_valid = res_valid_q;
    assign res       = res_q;
    assign err       = err_q;
    assign hilo      = hilo_q;

endmodule

// File: tb/tb_mul_acc_unit.sv
// Self-checking bench for mul_acc_unit: directed corner cases plus random ops
// compared against a plain-arithmetic model of HI/LO and the result register.
module tb_mul_acc_unit;
    import mul_acc_unit_pkg::*;

    localparam int DW  = 32;
    localparam int STG = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid, op_valid_n, flush;
    logic [3:0]    op;
    logic [DW-1:0] src_a, src_b;

    logic          op_ready, res_valid, err;
    logic [DW-1:0] res;
    logic [63:0]   hilo;
    logic          op_ready_n, res_valid_n, err_n;
    logic [DW-1:0] res_n;
    logic [63:0]   hilo_n;

    int checks = 0;
    int errors = 0;

    logic [63:0]   hilo_m;
    logic [63:0]   nhilo_m;
    logic [DW-1:0] res_m;

    mul_acc_unit #(.DATA_W(DW), .MUL_STAGES(STG), .ACC_EN(1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .op_ready(op_ready), .res_valid(res_valid), .res(res), .err(err), .hilo(hilo)
    );

    mul_acc_unit #(.DATA_W(DW), .MUL_STAGES(STG), .ACC_EN(0)) dut_noacc (
        .clk(clk), .rst(rst), .op_valid(op_valid_n), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .op_ready(op_ready_n), .res_valid(res_valid_n), .res(res_n), .err(err_n), .hilo(hilo_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint sa;
        longint sb;
        if (o inside {MOP_MULTU, MOP_MADDU, MOP_MSUBU}) begin
            return {32'b0, a} * {32'b0, b};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic issue(input bit to_noacc, input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (to_noacc) op_valid_n = 1'b1;
        else          op_valid   = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk); #1;
        op_valid   = 1'b0;
        op_valid_n = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [63:0] p;
        int          lat;
        p = ref_product(o, a, b);
        issue(1'b0, o, a, b);
        if (o inside {MOP_MULT, MOP_MULTU, MOP_MUL, MOP_MADD, MOP_MADDU, MOP_MSUB, MOP_MSUBU}) begin
            check("mul_busy", op_ready, 1'b0);
            check("mul_err", err, 1'b0);
            lat = 0;
            for (int c = 1; c <= 8; c++) begin
                step();
                if (res_valid) begin
                    lat = c;
                    break;
                end
            end
            check("mul_latency", lat, STG);
            case (o)
                MOP_MULT, MOP_MULTU: hilo_m = p;
                MOP_MADD, MOP_MADDU: hilo_m = hilo_m + p;
                MOP_MSUB, MOP_MSUBU: hilo_m = hilo_m - p;
                default:             res_m  = p[DW-1:0];
            endcase
            check("mul_hilo", hilo, hilo_m);
            check("mul_res", res, res_m);
            check("mul_ready", op_ready, 1'b1);
            step();
            check("mul_rv_pulse", res_valid, 1'b0);
        end else if (o == MOP_MTHI || o == MOP_MTLO) begin
            if (o == MOP_MTHI) hilo_m[63:32] = a;
            else               hilo_m[31:0]  = a;
            check("mt_hilo", hilo, hilo_m);
            check("mt_rv", res_valid, 1'b0);
            check("mt_ready", op_ready, 1'b1);
            check("mt_res_hold", res, res_m);
        end else if (o == MOP_MFHI || o == MOP_MFLO) begin
            res_m = (o == MOP_MFHI) ? hilo_m[63:32] : hilo_m[31:0];
            check("mf_rv", res_valid, 1'b1);
            check("mf_res", res, res_m);
            check("mf_ready", op_ready, 1'b1);
            step();
            check("mf_rv_pulse", res_valid, 1'b0);
        end else begin
            check("undef_err", err, 1'b1);
            check("undef_hilo", hilo, hilo_m);
            check("undef_rv", res_valid, 1'b0);
            step();
            check("undef_err_pulse", err, 1'b0);
        end
    endtask

    task automatic watch_no_result(input string tag);
        int seen;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (res_valid) seen++;
            step();
        end
        check(tag, seen, 0);
        check({tag, "_hilo"}, hilo, hilo_m);
    endtask

    task automatic flush_test(input int at);
        issue(1'b0, MOP_MULT, 32'd5, 32'd7);
        if (at == 2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_ready", op_ready, 1'b1);
        watch_no_result("flush_no_rv");
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_valid_n = 1'b0; flush = 1'b0;
        op = '0; src_a = '0; src_b = '0;
        hilo_m = '0; nhilo_m = '0; res_m = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hilo", hilo, 64'd0);
        check("rst_res", res, 32'd0);
        check("rst_rv", res_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready", op_ready, 1'b1);
        rst = 1'b0;
        step();

        run_op(MOP_MULT, 32'hFFFF_FFFF, 32'd2);
        check("mult_neg", hilo, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(MOP_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu_big", hilo, 64'h0000_0001_FFFF_FFFE);

        run_op(MOP_MTHI, 32'd1, 32'd0);
        run_op(MOP_MTLO, 32'd0, 32'd0);
        run_op(MOP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("maddu_wrap", hilo, 64'hFFFF_FFFF_0000_0001);
        run_op(MOP_MTHI, 32'd0, 32'd0);
        run_op(MOP_MTLO, 32'd0, 32'd0);
        run_op(MOP_MSUB, 32'd3, 32'hFFFF_FFFE);
        check("msub_neg", hilo, 64'd6);

        run_op(MOP_MTHI, 32'h0000_ABCD, 32'd0);
        run_op(MOP_MUL, 32'h0001_0000, 32'h0001_0000);
        check("mul_low_zero", res, 32'd0);
        check("mul_hilo_keep", hilo, 64'h0000_ABCD_0000_0006);
        run_op(MOP_MFHI, 32'd0, 32'd0);
        check("mfhi_prior", res, 32'h0000_ABCD);

        flush_test(1);
        flush_test(2);

        // Flush with nothing in flight blocks a same-cycle request.
        op_valid = 1'b1; op = MOP_MTHI; src_a = 32'hDEAD_BEEF; flush = 1'b1;
        step();
        op_valid = 1'b0; flush = 1'b0;
        check("idle_flush_hilo", hilo, hilo_m);
        check("idle_flush_ready", op_ready, 1'b1);

        // Reset one cycle after an accumulate is accepted.
        issue(1'b0, MOP_MADD, 32'd5, 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        hilo_m = '0; res_m = '0; nhilo_m = '0;
        check("rst_mid_ready", op_ready, 1'b1);
        watch_no_result("rst_mid_no_rv");

        // Accumulate ops are illegal when accumulation is disabled.
        issue(1'b1, MOP_MTLO, 32'h0000_1234, 32'd0);
        nhilo_m = 64'h0000_0000_0000_1234;
        check("noacc_mtlo", hilo_n, nhilo_m);
        issue(1'b1, MOP_MADD, 32'd3, 32'd4);
        check("noacc_err", err_n, 1'b1);
        check("noacc_hilo", hilo_n, nhilo_m);
        check("noacc_rv", res_valid_n, 1'b0);
        step();
        check("noacc_err_pulse", err_n, 1'b0);
        issue(1'b1, MOP_MULT, 32'd3, 32'd4);
        repeat (STG) step();
        check("noacc_mult", hilo_n, 64'd12);

        for (int n = 0; n < 300; n++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            run_op(o, pick(), pick());
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
